id_stage_pipe: RTL and testbench

//  Pipelined LEGv8 instruction-decode stage: register file, per-format immediate extraction,
//  and a one-entry ID/EX output register with valid/ready handshake and flush. Sits between
//  IF/ID and EX; writeback from WB feeds the internal register file with same-cycle bypass.

---
 rtl/id_stage_pipe.sv | 117 +++++++++++
 tb/tb_id_stage_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - LEGv8 decode stage: regfile, immediate extract, ID/EX register (optional XZR_EN: X31 reads zero)
module id_stage_pipe #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32,
    parameter int REG_NUM   = 32,
    localparam int REG_AW   = $clog2(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_SIZE-1:0] inst,
    input  logic                 Reg2Loc,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [REG_AW-1:0]    wb_addr,
    input  logic [WORD-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      r_data1,
    output logic [WORD-1:0]      r_data2,
    output logic [WORD-1:0]      ex_data,
    output logic [REG_AW-1:0]    rd
);

    localparam logic [REG_AW-1:0] XZR_ADDR = REG_AW'(REG_NUM - 1);

    logic [WORD-1:0]   regs_q [REG_NUM];
    logic              valid_q, valid_d;
    logic [WORD-1:0]   r1_q, r1_d, r2_q, r2_d, ex_q, ex_d;
    logic [REG_AW-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [REG_AW-1:0] rn_addr, rm_addr;
    logic [WORD-1:0]   imm;
    logic              wr_ok, capture, hold;

    // X31 is never written when the zero register is enabled, so it stays at its reset value of 0
`ifdef XZR_EN
    assign wr_ok = wb_en & (wb_addr != XZR_ADDR);
`else
    assign wr_ok = wb_en;
`endif

    assign rn_addr  = REG_AW'(inst[9:5]);
    assign rm_addr  = Reg2Loc ? REG_AW'(inst[4:0]) : REG_AW'(inst[20:16]);
    assign in_ready = ~valid_q | out_ready;
    assign capture  = in_valid & in_ready & ~flush;
    assign hold     = valid_q & ~out_ready;

    function automatic logic [WORD-1:0] rd_val(input logic [REG_AW-1:0] a);
        return (wr_ok && wb_addr == a) ? wb_data : regs_q[a];
    endfunction

    always_comb begin
        imm = {{(WORD-INST_SIZE){1'b0}}, inst};
        if (inst[31:26] == 6'b000101)
            imm = {{(WORD-26){inst[25]}}, inst[25:0]};
        else if (inst[31:25] == 7'b1011010)
            imm = {{(WORD-19){inst[23]}}, inst[23:5]};
        else if (inst[31:23] == 9'b111110000 && !inst[21])
            imm = {{(WORD-9){inst[20]}}, inst[20:12]};
        else if (inst[31:22] == 10'b1001000100 || inst[31:22] == 10'b1101000100)
            imm = {{(WORD-12){1'b0}}, inst[21:10]};
    end

    always_comb begin
        valid_d = capture | hold;
        r1_d    = r1_q;
        r2_d    = r2_q;
        ex_d    = ex_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        if (flush)
            valid_d = 1'b0;
        if (capture) begin
            r1_d = rd_val(rn_addr);
            r2_d = rd_val(rm_addr);
            ex_d = imm;
            rd_d = REG_AW'(inst[4:0]);
            rn_d = rn_addr;
            rm_d = rm_addr;
        end else if (hold) begin
            // keep the parked entry coherent with writebacks that land while it waits
            if (wr_ok && wb_addr == rn_q) r1_d = wb_data;
            if (wr_ok && wb_addr == rm_q) r2_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            r1_q    <= '0;
            r2_q    <= '0;
            ex_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            ex_q    <= ex_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            if (wr_ok) regs_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid = valid_q;
    assign r_data1   = r1_q;
    assign r_data2   = r2_q;
    assign ex_data   = ex_q;
    assign rd        = rd_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, Reg2Loc, flush, wb_en, out_valid, out_ready;
    logic [31:0] inst;
    logic [4:0]  wb_addr, rd;
    logic [63:0] wb_data, r_data1, r_data2, ex_data;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] iw;

    id_stage_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .Reg2Loc(Reg2Loc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .r_data1(r_data1), .r_data2(r_data2),
        .ex_data(ex_data), .rd(rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic r2l);
        in_valid = 1'b1;
        inst     = i;
        Reg2Loc  = r2l;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [63:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        tick();
        wb_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; inst = '0; Reg2Loc = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_r_data1", r_data1, 64'd0);
        chk("rst_r_data2", r_data2, 64'd0);
        chk("rst_ex_data", ex_data, 64'd0);
        chk("rst_rd", {59'd0, rd}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;

        // every register reads back zero after reset
        for (int i = 0; i < 32; i++) begin
            iw = 32'h8B00_0000 | (i << 5) | i;
            issue(iw, 1'b1);
            chk("rst_read_valid", {63'd0, out_valid}, 64'd1);
            chk("rst_read_rn", r_data1, 64'd0);
            chk("rst_read_rm", r_data2, 64'd0);
        end
        tick();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        wb(5'd22, 64'd22);
        wb(5'd4, 64'd4);
        wb(5'd9, 64'd99);
        issue(32'hF844_02C9, 1'b0);
        chk("ldur_r1", r_data1, 64'd22);
        chk("ldur_r2_rm", r_data2, 64'd4);
        chk("ldur_ex", ex_data, 64'd64);
        chk("ldur_rd", {59'd0, rd}, 64'd9);
        issue(32'hF844_02C9, 1'b1);
        chk("ldur_r2_rt", r_data2, 64'd99);

        issue(32'hB4FF_FF6B, 1'b1);
        chk("cbz_ex", ex_data, 64'hFFFF_FFFF_FFFF_FFFB);
        issue(32'h17FF_FFC9, 1'b0);
        chk("b_ex", ex_data, 64'hFFFF_FFFF_FFFF_FFC9);
        issue(32'h8B09_026A, 1'b0);
        chk("add_ex", ex_data, 64'h0000_0000_8B09_026A);
        chk("add_rd", {59'd0, rd}, 64'd10);
        issue(32'h913F_FC00, 1'b0);
        chk("addi_ex", ex_data, 64'h0000_0000_0000_0FFF);
        issue(32'hD120_0000, 1'b0);
        chk("subi_ex", ex_data, 64'h0000_0000_0000_0800);
        issue(32'hF81F_F000, 1'b0);
        chk("stur_ex", ex_data, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("idle_valid", {63'd0, out_valid}, 64'd0);

        // same-cycle writeback bypass
        wb_en = 1'b1; wb_addr = 5'd19; wb_data = 64'd7;
        issue(32'h8B09_026A, 1'b0);
        wb_en = 1'b0;
        chk("bypass_r1", r_data1, 64'd7);
        chk("bypass_r2", r_data2, 64'd99);
        issue(32'h8B09_026A, 1'b0);
        chk("bypass_written", r_data1, 64'd7);
        tick();

        // stall with snoop
        out_ready = 1'b0;
        issue(32'h8B09_026A, 1'b0);
        chk("stall_cap_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b1; inst = 32'h17FF_FFC9;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("stall1_ex", ex_data, 64'h0000_0000_8B09_026A);
        wb(5'd9, 64'd5);
        chk("snoop_r2", r_data2, 64'd5);
        chk("stall2_r1", r_data1, 64'd7);
        wb(5'd19, 64'd33);
        chk("snoop_r1", r_data1, 64'd33);
        chk("stall3_valid", {63'd0, out_valid}, 64'd1);
        chk("stall3_ex", ex_data, 64'h0000_0000_8B09_026A);
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("release_next_ex", ex_data, 64'hFFFF_FFFF_FFFF_FFC9);
        chk("release_next_valid", {63'd0, out_valid}, 64'd1);
        tick();
        chk("release_drained", {63'd0, out_valid}, 64'd0);

        // flush of incoming and of held entry
        flush = 1'b1;
        issue(32'h8B09_026A, 1'b0);
        flush = 1'b0;
        chk("flush_in_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;
        issue(32'h8B09_026A, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_held_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;

        // X31
        wb(5'd31, 64'd9);
        issue(32'h8B1F_03E0, 1'b0);
`ifdef XZR_EN
        chk("x31_read", r_data1, 64'd0);
`else
        chk("x31_read", r_data1, 64'd9);
`endif
        wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'd11;
        issue(32'h8B1F_03E0, 1'b0);
        wb_en = 1'b0;
`ifdef XZR_EN
        chk("x31_bypass", r_data2, 64'd0);
`else
        chk("x31_bypass", r_data2, 64'd11);
`endif

        // reset while stalled
        out_ready = 1'b0;
        issue(32'h8B09_026A, 1'b0);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_r1", r_data1, 64'd0);
        out_ready = 1'b1;
        issue(32'h8B09_026A, 1'b0);
        chk("midrst_regs_cleared", r_data2, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
